multicycle_control_unit: RTL

Sequential control unit for the multi-cycle MIPS datapath, replacing single-cycle combinational decode. A state machine steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and handles variable-latency instruction and data memories through req/ack handshakes. Features not in the single-cycle unit: a bounded memory-wait timeout, trapping on illegal opcodes with no architectural writes, and a retired-instruction counter. It sits between the instruction register/flag outputs of the datapath and every mux select and write enable in it.

---
 rtl/mips_pkg.sv | 81 ++++++++
 rtl/multicycle_control_unit_if.sv | 18 +
 rtl/mc_decode.sv | 68 ++++++
 rtl/multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types for the MIPS datapath and its multi-cycle
//               control unit: opcode/function encodings, ALU operations,
//               control FSM states and instruction classes.
// Revision    : 1.0 - initial multi-cycle control release
// ============================================================================
package mips_pkg;

    typedef logic [5:0] op_t;
    typedef logic [5:0] func_t;

    // Primary opcodes
    localparam op_t OP_RTYPE = 6'h00;
    localparam op_t OP_ADDI  = 6'h01;
    localparam op_t OP_ANDI  = 6'h02;
    localparam op_t OP_ORI   = 6'h03;
    localparam op_t OP_XORI  = 6'h04;
    localparam op_t OP_SLTI  = 6'h05;
    localparam op_t OP_LUI   = 6'h06;
    localparam op_t OP_LLI   = 6'h07;
    localparam op_t OP_LI    = 6'h08;
    localparam op_t OP_LW    = 6'h09;
    localparam op_t OP_SW    = 6'h0A;
    localparam op_t OP_BEQ   = 6'h0B;
    localparam op_t OP_BNEQ  = 6'h0C;
    localparam op_t OP_BZ    = 6'h0D;
    localparam op_t OP_BNEG  = 6'h0E;
    localparam op_t OP_J     = 6'h0F;
    localparam op_t OP_JAL   = 6'h10;
    localparam op_t OP_JR    = 6'h11;

    // R-type function codes
    localparam func_t F_ADD = 6'h00;
    localparam func_t F_SUB = 6'h01;
    localparam func_t F_AND = 6'h02;
    localparam func_t F_OR  = 6'h03;
    localparam func_t F_XOR = 6'h04;
    localparam func_t F_SLT = 6'h05;
    localparam func_t F_SLL = 6'h06;
    localparam func_t F_SRL = 6'h07;
    localparam func_t F_SRA = 6'h08;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_LUI   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } mc_state_t;

    typedef enum logic [3:0] {
        C_RALU    = 4'd0,
        C_IALU    = 4'd1,
        C_LOAD    = 4'd2,
        C_STORE   = 4'd3,
        C_BRANCH  = 4'd4,
        C_J       = 4'd5,
        C_JAL     = 4'd6,
        C_JR      = 4'd7,
        C_ILLEGAL = 4'd8
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Instruction/data memory request-acknowledge bundle between
//               the control unit (master) and the memory system (slave).
// Revision    : 1.0 - initial multi-cycle control release
// ============================================================================
interface multicycle_control_unit_if;
    logic im_req;
    logic im_ack;
    logic dm_req;
    logic dm_we;
    logic dm_ack;

    modport master (output im_req, dm_req, dm_we, input im_ack, dm_ack);
    modport slave  (input im_req, dm_req, dm_we, output im_ack, dm_ack);
endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational instruction decode: classifies an opcode /
//               function pair and produces the ALU controls and the
//               destination-register select for that instruction.
// Revision    : 1.0 - initial multi-cycle control release
// ============================================================================
module mc_decode
    import mips_pkg::*;
(
    input  op_t          dec_op,
    input  func_t        dec_func,
    output instr_class_t iclass,
    output alu_op_t      alu_op,
    output logic         alu_a_sel,
    output logic         Qt_imm_sel,
    output logic         rd_sel
);

    // Opcode/function table; anything not listed classifies as illegal
    always_comb begin
        iclass     = C_ILLEGAL;
        alu_op     = ALU_ADD;
        alu_a_sel  = 1'b0;
        Qt_imm_sel = 1'b0;
        rd_sel     = 1'b0;
        case (dec_op)
            OP_RTYPE: begin
                iclass     = C_RALU;
                Qt_imm_sel = 1'b1;
                case (dec_func)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLL:   begin alu_op = ALU_SLL; alu_a_sel = 1'b1; end
                    F_SRL:   begin alu_op = ALU_SRL; alu_a_sel = 1'b1; end
                    F_SRA:   begin alu_op = ALU_SRA; alu_a_sel = 1'b1; end
                    default: begin iclass = C_ILLEGAL; Qt_imm_sel = 1'b0; end
                endcase
            end
            OP_ADDI: begin iclass = C_IALU; rd_sel = 1'b1; end
            OP_ANDI: begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_AND;   end
            OP_ORI:  begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_OR;    end
            OP_XORI: begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_XOR;   end
            OP_SLTI: begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_SLT;   end
            OP_LUI:  begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_LUI;   end
            OP_LLI:  begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_PASSB; end
            OP_LI:   begin iclass = C_IALU; rd_sel = 1'b1; alu_op = ALU_PASSB; end
            OP_LW:   begin iclass = C_LOAD; rd_sel = 1'b1; end
            OP_SW:   iclass = C_STORE;
            OP_BEQ, OP_BNEQ, OP_BZ, OP_BNEG: begin
                iclass     = C_BRANCH;
                alu_op     = ALU_SUB;
                Qt_imm_sel = 1'b1;
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            OP_JR:   iclass = C_JR;
            default: iclass = C_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with req/ack memory handshakes, bounded memory wait,
//               illegal-opcode trap and retired-instruction counter.
// Revision    : 1.0 - initial multi-cycle control release
// ============================================================================
module multicycle_control_unit
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  op_t                       op,
    input  func_t                     func,
    input  logic                      eq,
    input  logic                      zero,
    input  logic                      neg,
    multicycle_control_unit_if.master bus,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic                      pc_sel,
    output logic                      jr_sel,
    output logic                      rf_we,
    output logic                      rd_sel,
    output logic                      jump_address_sel,
    output logic                      jump_data_sel,
    output logic                      data_in_sel,
    output logic                      alu_a_sel,
    output logic                      Qt_imm_sel,
    output alu_op_t                   alu_op,
    output mc_state_t                 state,
    output logic                      illegal_op,
    output logic                      bus_err,
    output logic [RET_CNT_W-1:0]      retired
);

    // A zero timeout still needs a 1-bit counter to keep widths legal
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The wait that would bring the counter to MEM_TIMEOUT is the last one
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    mc_state_t           state_q, state_d;
    op_t                 op_q;
    func_t               func_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                illegal_q, bus_err_q;
    logic [RET_CNT_W-1:0] retired_q;
    logic                set_illegal, set_bus_err, timeout_hit, taken;
    logic                im_req, dm_req, dm_we;
    op_t                 dec_op;
    func_t               dec_func;
    instr_class_t        dec_class;
    alu_op_t             dec_alu_op;
    logic                dec_a_sel, dec_qt_sel, dec_rd_sel;

    // DECODE judges legality on the live IR; every later state uses the copy
    assign dec_op   = (state_q == S_DECODE) ? op   : op_q;
    assign dec_func = (state_q == S_DECODE) ? func : func_q;

    mc_decode u_decode (
        .dec_op     (dec_op),
        .dec_func   (dec_func),
        .iclass     (dec_class),
        .alu_op     (dec_alu_op),
        .alu_a_sel  (dec_a_sel),
        .Qt_imm_sel (dec_qt_sel),
        .rd_sel     (dec_rd_sel)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    // Branch condition selected by the latched opcode
    always_comb begin
        case (op_q)
            OP_BEQ:  taken = eq;
            OP_BNEQ: taken = !eq;
            OP_BZ:   taken = zero;
            OP_BNEG: taken = neg;
            default: taken = 1'b0;
        endcase
    end

    // Next state and all control outputs; everything idles while in reset
    always_comb begin
        state_d          = state_q;
        im_req           = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = 1'b0;
        jr_sel           = 1'b0;
        rf_we            = 1'b0;
        rd_sel           = 1'b0;
        jump_address_sel = 1'b1;
        jump_data_sel    = 1'b0;
        data_in_sel      = 1'b0;
        alu_a_sel        = 1'b0;
        Qt_imm_sel       = 1'b0;
        alu_op           = ALU_ADD;
        dm_req           = 1'b0;
        dm_we            = 1'b0;
        set_illegal      = 1'b0;
        set_bus_err      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    im_req = 1'b1;
                    if (bus.im_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (dec_class == C_ILLEGAL) begin
                        set_illegal = 1'b1;
                        state_d     = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_op     = dec_alu_op;
                    alu_a_sel  = dec_a_sel;
                    Qt_imm_sel = dec_qt_sel;
                    case (dec_class)
                        C_RALU, C_IALU, C_JAL: state_d = S_WB;
                        C_LOAD, C_STORE:       state_d = S_MEM;
                        C_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = taken;
                            state_d = S_FETCH;
                        end
                        C_J: begin
                            pc_we   = 1'b1;
                            pc_sel  = 1'b1;
                            state_d = S_FETCH;
                        end
                        C_JR: begin
                            pc_we   = 1'b1;
                            jr_sel  = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    dm_req = 1'b1;
                    dm_we  = (dec_class == C_STORE);
                    if (bus.dm_ack) begin
                        if (dec_class == C_STORE) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_WB: begin
                    rf_we       = 1'b1;
                    rd_sel      = dec_rd_sel;
                    data_in_sel = (dec_class != C_LOAD);
                    if (dec_class == C_JAL) begin
                        jump_address_sel = 1'b0;
                        jump_data_sel    = 1'b1;
                        pc_sel           = 1'b1;
                    end
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_TRAP;
            endcase
        end
    end

    // Wait counter: zero outside a request, counts unacknowledged request cycles
    always_comb begin
        wait_d = '0;
        if (!rst && (MEM_TIMEOUT != 0) &&
            (((state_q == S_FETCH) && !bus.im_ack) ||
             ((state_q == S_MEM)   && !bus.dm_ack))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched IR fields, wait counter, sticky traps and retired count
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            func_q    <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q   <= op;
                func_q <= func;
            end
            wait_q <= wait_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
            if (pc_we)       retired_q <= retired_q + RET_CNT_W'(1);
        end
    end

    assign bus.im_req = im_req;
    assign bus.dm_req = dm_req;
    assign bus.dm_we  = dm_we;
    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire
